// File: rtl/ysyx_22050598_ifu_fq.sv
// Instruction fetch unit: generates the fetch PC, issues one outstanding aligned
// I-cache read at a time, and buffers returned instructions in a small FIFO for decode.
module ysyx_22050598_ifu_fq #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000),
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_stall,
  input  logic            flush_pc_en,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            prdt_pc_en,
  input  logic [XLEN-1:0] prdt_pc_add_op,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [63:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fq_entry_t        fq_q [FQ_DEPTH];

  logic            req_fire_c;
  logic            resp_c;
  logic            push_c;
  logic            pop_c;
  logic [31:0]     word_c;
  fq_entry_t       push_entry_c;

  // Credit-based issue: a request only goes out if its response is guaranteed a slot.
  assign imem_req  = ~rst & ~flush_pc_en & ~pc_stall & ~inflight_q & (count_q < FULL_CNT);
  assign imem_addr = {fetch_pc_q[XLEN-1:3], 3'b000};

  assign id_valid = (count_q != '0);
  assign id_inst  = fq_q[rd_ptr_q].inst;
  assign id_pc    = fq_q[rd_ptr_q].pc;

  assign req_fire_c = imem_req & imem_ack;
  assign resp_c     = imem_rvalid & inflight_q;
  assign pop_c      = id_valid & id_ready;
  assign word_c     = inflight_pc_q[2] ? imem_rdata[63:32] : imem_rdata[31:0];

  always_comb begin
    push_entry_c.inst = word_c;
    push_entry_c.pc   = inflight_pc_q;
  end

  // Next-state logic; flush overrides any same-cycle issue, push or pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    push_c        = 1'b0;

    if (flush_pc_en) begin
      fetch_pc_d = flush_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // A response still owed after this cycle belongs to the old path.
      inflight_d = inflight_q & ~imem_rvalid;
      drop_d     = inflight_q & ~imem_rvalid;
    end else begin
      if (req_fire_c) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + (prdt_pc_en ? prdt_pc_add_op : XLEN'(4));
      end

      if (resp_c) begin
        inflight_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          push_c = (count_q != FULL_CNT);
        end
      end

      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        fq_q[i] <= '0;
      end
    end else if (push_c) begin
      fq_q[wr_ptr_q] <= push_entry_c;
    end
  end

endmodule

// File: doc/ysyx_22050598_ifu_fq.md
# ysyx_22050598_ifu_fq

Parametrised instruction fetch unit with a decoupling fetch queue. Generates the fetch PC (sequential or predicted-offset), issues 8-byte-aligned read requests to the instruction cache over a req/ack + rvalid handshake, and buffers returned instructions with their PCs in a FQ_DEPTH-entry FIFO drained by decode via valid/ready. Redirects (flush) clear the queue and discard any in-flight response. Sits between the I-cache and the decode stage of the pipeline.

## Interface
- XLEN, 64, PC/address width
- RESET_PC, 64'h0000000080000000, PC loaded on reset
- FQ_DEPTH, 4, fetch queue entries; power of two, >= 2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc_stall  in  1  1 = suppress new fetch requests (queue still drains)
- flush_pc_en  in  1  redirect request
- flush_pc  in  XLEN  redirect target
- prdt_pc_en  in  1  predicted-taken for the request accepted this cycle
- prdt_pc_add_op  in  XLEN  offset added to fetch PC when prdt_pc_en
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  {fetch_pc[XLEN-1:3],3'b0}
- imem_ack  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  64  aligned doubleword
- id_valid  out  1  queue head valid
- id_ready  in  1  decode accepts head
- id_inst  out  32  head instruction
- id_pc  out  XLEN  head PC

## Operation
- State: fetch_pc (XLEN), inflight (1), drop (1), inflight_pc (XLEN), queue rd/wr pointers (log2 FQ_DEPTH) and count (log2 FQ_DEPTH + 1).
- Reset: fetch_pc=RESET_PC, inflight=0, drop=0, pointers/count=0; imem_req=0, id_valid=0.
- imem_req = ~rst & ~flush_pc_en & ~pc_stall & ~inflight & (count < FQ_DEPTH); combinational from state. At most one outstanding request.
- imem_req & imem_ack: inflight<=1, inflight_pc<=fetch_pc, fetch_pc <= fetch_pc + (prdt_pc_en ? prdt_pc_add_op : 4), modulo 2^XLEN.
- imem_rvalid with inflight: inflight<=0; if drop, drop<=0 and data discarded; else push {inflight_pc[2] ? imem_rdata[63:32] : imem_rdata[31:0], inflight_pc}. imem_rvalid with inflight=0 is ignored.
- Credit rule (count < FQ_DEPTH at issue, one outstanding) guarantees push never hits a full queue; push when full is a protocol error, entry dropped.
- Pop on id_valid & id_ready; simultaneous push and pop keeps count unchanged.
- id_valid = (count != 0); id_inst/id_pc from rd pointer entry.
- Flush (highest priority): fetch_pc<=flush_pc, pointers/count<=0 (same-cycle push/pop ignored), drop<=1 iff a request is outstanding after this cycle (inflight & ~imem_rvalid, or ack in this cycle — but imem_req is 0 during flush, so ack is ignored). rvalid in the flush cycle is discarded, drop stays 0.
- While drop=1 no new request is issued (inflight=1).

## Timing
- Request to queue: response in cycle N -> id_valid=1 in N+1.
- Flush in cycle N with nothing in flight -> imem_req with imem_addr=flush_pc aligned in N+1 (if not stalled).
- Flush with request in flight -> first new request the cycle after the dropped response returns.
- Pointers wrap modulo FQ_DEPTH; count never exceeds FQ_DEPTH.
- rst mid-transaction: all state returns to reset values next cycle; a later rvalid for the old request is ignored (inflight=0).

## Test plan
- Reset, imem_ack/rvalid 1-cycle latency, id_ready=1: imem_addr 0x80000000 twice (PCs 0x80000000, 0x80000004), id_inst selects rdata[31:0] then [63:32], id_pc matches.
- id_ready=0, FQ_DEPTH=4: exactly 4 requests issued, imem_req=0 afterwards, count=4; raise id_ready -> one pop per cycle, requests resume.
- prdt_pc_en=1, op=0x10 on ack at 0x80000008 -> next imem_addr 0x80000018 (pc 0x80000018, word select [31:0]).
- Flush to 0x80001004 while request in flight: queue empties next cycle, stale rvalid discarded, next request addr 0x80001000, head id_pc 0x80001004, id_inst=rdata[63:32].
- Flush coincident with rvalid and with id_ready pop: no push, count=0, drop=0, new request next cycle.
- Assert rst with inflight=1, then rvalid: no push, id_valid=0, imem_addr 0x80000000.
